// File: rtl/button_pkg.sv
// Shared push-button definitions: decoder state type and default timing.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESSED     = 3'd1,
        LONG_HELD   = 3'd2,
        WAIT_GAP    = 3'd3,
        SECOND_HELD = 3'd4
    } state_e;

    // 0.5 s long press and 0.25 s click gap at 100 MHz.
    localparam int DEFAULT_LONG_TICKS = 50_000_000;
    localparam int DEFAULT_GAP_TICKS  = 25_000_000;
    localparam int DEFAULT_CNT_W      = 27;

endpackage

// File: rtl/button_edge_detect.sv
// Registered rise/fall detector on a clock-synchronous level.
module button_edge_detect (
    input  logic clock_i,
    input  logic reset_i,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_i;
            rise_q  <= level_i & ~level_q;
            fall_q  <= ~level_i & level_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into press/release/click/double/long pulses.
module button_event_decoder
    import button_pkg::*;
#(
    parameter int LONG_TICKS = DEFAULT_LONG_TICKS,
    parameter int GAP_TICKS  = DEFAULT_GAP_TICKS,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic single_click_o,
    output logic double_click_o,
    output logic long_press_o
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             single_q, single_d;
    logic             double_q, double_d;
    logic             long_q, long_d;

    button_edge_detect u_edge (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .level_i (btn_i),
        .rise_o  (press_o),
        .fall_o  (release_o)
    );

    // Thresholds are compared before incrementing, so cnt never exceeds them.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_i) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESSED: begin
                if (btn_i) begin
                    if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = LONG_HELD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = WAIT_GAP;
                    cnt_d   = CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (!btn_i) begin
                    state_d = IDLE;
                end
            end
            WAIT_GAP: begin
                if (btn_i) begin
                    double_d = 1'b1;
                    state_d  = SECOND_HELD;
                end else if (cnt_q == GAP_LAST) begin
                    single_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SECOND_HELD: begin
                if (!btn_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
        end
    end

    assign single_click_o = single_q;
    assign double_click_o = double_q;
    assign long_press_o   = long_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed plus random bench for button_event_decoder against a run-length model.
module tb_button_event_decoder;

    localparam int LONG = 8;
    localparam int GAP  = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn   = 1'b0;
    logic press, rel, single_click, double_click, long_press;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Reference model: tracks run lengths of high/low samples and whether
    // the current high run is a first press or the second press of a double.
    logic m_prev    = 1'b0;
    logic m_pending = 1'b0;
    logic m_second  = 1'b0;
    int   m_hi      = 0;
    int   m_lo      = 0;
    logic e_press, e_rel, e_single, e_double, e_long;

    button_event_decoder #(
        .LONG_TICKS (LONG),
        .GAP_TICKS  (GAP),
        .CNT_W      (4)
    ) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .btn_i          (btn),
        .press_o        (press),
        .release_o      (rel),
        .single_click_o (single_click),
        .double_click_o (double_click),
        .long_press_o   (long_press)
    );

    always #5 clock = ~clock;

    task automatic model(input logic b, input logic r);
        e_press  = 1'b0;
        e_rel    = 1'b0;
        e_single = 1'b0;
        e_double = 1'b0;
        e_long   = 1'b0;
        if (r) begin
            m_prev    = 1'b0;
            m_pending = 1'b0;
            m_second  = 1'b0;
            m_hi      = 0;
            m_lo      = 0;
            return;
        end
        if (b) begin
            if (!m_prev) begin
                e_press  = 1'b1;
                m_hi     = 1;
                m_second = m_pending;
                e_double = m_pending;
                m_pending = 1'b0;
            end else begin
                m_hi++;
            end
            if (!m_second && m_hi == LONG) e_long = 1'b1;
        end else begin
            if (m_prev) begin
                e_rel     = 1'b1;
                m_lo      = 1;
                m_pending = !m_second && (m_hi < LONG);
            end else begin
                m_lo++;
            end
            if (m_pending && m_lo == GAP) begin
                e_single  = 1'b1;
                m_pending = 1'b0;
            end
        end
        m_prev = b;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %b expected %b at cycle %0d", tag, got, exp, cyc);
    endtask

    task automatic step(input logic b, input logic r);
        @(negedge clock);
        btn   = b;
        reset = r;
        @(posedge clock);
        #1;
        cyc++;
        model(b, r);
        chk("press", press, e_press);
        chk("release", rel, e_rel);
        chk("single_click", single_click, e_single);
        chk("double_click", double_click, e_double);
        chk("long_press", long_press, e_long);
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        $display("phase reset/idle");
        hold(1'b0, 20);

        $display("phase single click");
        hold(1'b1, 3);  hold(1'b0, 6);

        $display("phase long press");
        hold(1'b1, 12); hold(1'b0, 10);

        $display("phase double click");
        hold(1'b1, 2);  hold(1'b0, 4);  hold(1'b1, 2);  hold(1'b0, 10);

        $display("phase gap boundary -> two single clicks");
        hold(1'b1, 2);  hold(1'b0, 5);  hold(1'b1, 2);  hold(1'b0, 10);

        $display("phase reset while held");
        hold(1'b1, 3);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        hold(1'b1, 12); hold(1'b0, 8);

        $display("phase triple press");
        for (int k = 0; k < 3; k++) begin
            hold(1'b1, 2);
            hold(1'b0, 2);
        end
        hold(1'b0, 8);

        $display("phase random runs");
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 29) == 0) step(1'b0, 1'b1);
            hold(k[0] ? 1'b0 : 1'b1, int'($urandom_range(1, 11)));
        end
        hold(1'b0, 8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumer end of the push-button path. Takes the clean, clock-synchronous level produced by the debouncer and decodes it into single-cycle user events: press, release, single click, double click, long press. Sits between the debouncer and any control FSM that reacts to buttons, so downstream logic never measures hold times itself.

## Interface

- LONG_TICKS, 50_000_000: consecutive high samples that make a long press (0.5 s at 100 MHz); must be ≥2 and < 2**CNT_W.
- GAP_TICKS, 25_000_000: consecutive low samples after a short press before it is declared a single click; same range rule.
- CNT_W, 27: hold/gap counter width.

- clock  input  1  rising-edge system clock.
- reset  input  1  synchronous, active-high reset.
- btn  input  1  debounced button level, already synchronous to clock.
- press  output  1  one-cycle pulse on each 0→1 of btn.
- release  output  1  one-cycle pulse on each 1→0 of btn.
- single_click  output  1  one-cycle pulse: short press not followed by a second press within GAP_TICKS.
- double_click  output  1  one-cycle pulse: second press started within the gap.
- long_press  output  1  one-cycle pulse: btn held LONG_TICKS samples.

## Operation

- Previous-sample register btn_d; press = btn & ~btn_d, release = ~btn & btn_d, evaluated every edge independent of state.
- Counter cnt, CNT_W bits, unsigned, never wraps (bounded by thresholds).
- States: IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_HELD.
- IDLE: btn=1 → PRESSED, cnt=1.
- PRESSED: btn=1 and cnt==LONG_TICKS-1 → long_press, LONG_HELD; btn=1 otherwise → cnt+1; btn=0 → WAIT_GAP, cnt=1.
- LONG_HELD: btn=0 → IDLE. No click reported for a long press.
- WAIT_GAP: btn=1 → double_click, SECOND_HELD; btn=0 and cnt==GAP_TICKS-1 → single_click, IDLE; else cnt+1.
- SECOND_HELD: btn=0 → IDLE. No long-press detection during the second press.
- Net effect: long_press on the LONG_TICKS-th consecutive high sample; single_click on the GAP_TICKS-th consecutive low sample counting the release sample; a triple press yields one double_click plus a fresh press sequence from IDLE.
- At most one of single_click / double_click / long_press per cycle; press/release may coincide with double_click (second press).

## Timing

- All outputs registered; a pulse is high for exactly the cycle after the edge where its condition was sampled. Latency btn→press/release = 1 cycle.
- Reset: state IDLE, cnt 0, btn_d 0, all outputs 0. Reset overrides all; no pulses in the cycle following a reset edge.
- Reset mid-operation: pending click/long decisions discarded. Since btn_d resets to 0, a button held through reset produces press on the first sample after deassertion and the long-press count restarts from 1.
- Threshold equality checked before increment; exact-boundary cases (gap of GAP_TICKS-1 lows then high) count as double click.

## Structure

- Package button_pkg: state enum typedef (IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_HELD) and default tick constants, shared with future multi-button blocks.
- Sub-module button_edge_detect (clock, reset, level → rise, fall, registered) instanced once; FSM and counter in the top module.

## Test plan

Parameters for bench: LONG_TICKS=8, GAP_TICKS=5, CNT_W=4.
- Reset, btn low 20 cycles → every output 0 throughout.
- btn high 3 samples, then low 6 → press at 1st high, release at 1st low, single_click at 5th low; no long_press/double_click.
- btn high 12 samples, then low 10 → long_press once at 8th high, release at 1st low; no single_click or double_click.
- high 2, low 4, high 2, low 10 → two press, two release pulses, double_click coincident with second press; no single_click. Repeat with low 5 → single_click at 5th low, second press then handled from IDLE (single_click after its own gap).
- Reset asserted for 2 cycles while in PRESSED with btn held, btn stays high → outputs 0 during reset, press on first sample after, long_press 8 samples later.
- Triple press high2/low2 ×3 → one double_click, then third press yields single_click after 5 lows.
